// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - bus bundle between the pipeline and the register file
//
// Purpose: groups the write port and the two read ports of the register file.
// Signals:
//   wr_en      write enable
//   wr_reg     write register index
//   wr_data    write data
//   rd_reg_1   read port 1 register index
//   rd_reg_2   read port 2 register index
//   rd_data_1  read port 1 data (driven by the register file)
//   rd_data_2  read port 2 data (driven by the register file)
// Modports:
//   master  pipeline side: drives indices/write data, receives read data
//   slave   register file side
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_reg;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH-1:0] rd_reg_1;
  logic [ADDR_WIDTH-1:0] rd_reg_2;
  logic [DATA_WIDTH-1:0] rd_data_1;
  logic [DATA_WIDTH-1:0] rd_data_2;

  modport master (
    output wr_en, wr_reg, wr_data, rd_reg_1, rd_reg_2,
    input  rd_data_1, rd_data_2
  );

  modport slave (
    input  wr_en, wr_reg, wr_data, rd_reg_1, rd_reg_2,
    output rd_data_1, rd_data_2
  );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - RV32I integer register file, 2 async read / 1 sync write
//
// Purpose: 32 x 32-bit architectural registers with x0 hard-wired to zero.
// Reads are combinational with no write bypass; forwarding is left to the
// pipeline. Reset is synchronous, active-high, and beats a same-cycle write.
// Ports:
//   clk_i  system clock, all state updates on the rising edge
//   rst_i  synchronous reset, active-high; clears every register
//   bus    register_file_if.slave: write port and two read ports
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  logic           clk_i,
  input  logic           rst_i,
  register_file_if.slave bus
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] rd_data_1;
  logic [DATA_WIDTH-1:0] rd_data_2;

  // Writes to x0 are dropped here so regs_q[0] stays at its reset value.
  assign wr_fire = bus.wr_en && (bus.wr_reg != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_fire) begin
      regs_d[bus.wr_reg] = bus.wr_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Index 0 is forced to zero on the read side as well, so x0 reads zero
  // even before the first reset has cleared the array.
  always_comb begin
    rd_data_1 = '0;
    if (bus.rd_reg_1 != '0) begin
      rd_data_1 = regs_q[bus.rd_reg_1];
    end
  end

  always_comb begin
    rd_data_2 = '0;
    if (bus.rd_reg_2 != '0) begin
      rd_data_2 = regs_q[bus.rd_reg_2];
    end
  end

  assign bus.rd_data_1 = rd_data_1;
  assign bus.rd_data_2 = rd_data_2;

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_reg  = idx;
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic read_pair(input logic [4:0] a, input logic [4:0] b);
    bus.rd_reg_1 = a;
    bus.rd_reg_2 = b;
    #1;
  endtask

  initial begin
    logic [31:0] pattern;
    rst          = 1'b1;
    bus.wr_en    = 1'b0;
    bus.wr_reg   = '0;
    bus.wr_data  = '0;
    bus.rd_reg_1 = '0;
    bus.rd_reg_2 = '0;
    pattern      = 32'h0101_0101;

    // 1. Reset clears every register, seen on both ports.
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_pair(5'(i), 5'(31 - i));
      check($sformatf("reset_p1_x%0d", i), bus.rd_data_1, 32'h0);
      check($sformatf("reset_p2_x%0d", 31 - i), bus.rd_data_2, 32'h0);
    end

    // 2. Basic write then read on both ports.
    write_reg(5'd5, 32'hDEAD_BEEF);
    read_pair(5'd5, 5'd5);
    check("wr5_p1", bus.rd_data_1, 32'hDEAD_BEEF);
    check("wr5_p2", bus.rd_data_2, 32'hDEAD_BEEF);

    // 3. x0 ignores writes.
    write_reg(5'd0, 32'hFFFF_FFFF);
    read_pair(5'd0, 5'd0);
    check("x0_p1", bus.rd_data_1, 32'h0);
    check("x0_p2", bus.rd_data_2, 32'h0);

    // 4. wr_en=0 leaves the target unchanged.
    write_reg(5'd7, 32'h1234_5678);
    bus.wr_en   = 1'b0;
    bus.wr_reg  = 5'd7;
    bus.wr_data = 32'hA5A5_A5A5;
    tick();
    read_pair(5'd7, 5'd5);
    check("wr_dis_x7", bus.rd_data_1, 32'h1234_5678);
    check("wr_dis_x5", bus.rd_data_2, 32'hDEAD_BEEF);

    // 5. Read-during-write: old value before the edge, new value after.
    write_reg(5'd3, 32'h1);
    bus.wr_en   = 1'b1;
    bus.wr_reg  = 5'd3;
    bus.wr_data = 32'h2;
    read_pair(5'd3, 5'd3);
    check("rdw_before_p1", bus.rd_data_1, 32'h1);
    check("rdw_before_p2", bus.rd_data_2, 32'h1);
    tick();
    bus.wr_en = 1'b0;
    check("rdw_after_p1", bus.rd_data_1, 32'h2);
    check("rdw_after_p2", bus.rd_data_2, 32'h2);

    // 6. Full sweep with distinct indices per port.
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), 32'(i) * pattern);
    end
    for (int i = 1; i < 32; i++) begin
      int j;
      j = (i % 31) + 1;
      read_pair(5'(i), 5'(j));
      check($sformatf("sweep_p1_x%0d", i), bus.rd_data_1, 32'(i) * pattern);
      check($sformatf("sweep_p2_x%0d", j), bus.rd_data_2, 32'(j) * pattern);
    end

    // Reset beats a simultaneous write.
    rst         = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_reg  = 5'd9;
    bus.wr_data = 32'hCAFE_F00D;
    tick();
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_pair(5'(i), 5'(i ^ 1));
      check($sformatf("rst_prio_p1_x%0d", i), bus.rd_data_1, 32'h0);
      check($sformatf("rst_prio_p2_x%0d", i ^ 1), bus.rd_data_2, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
